register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, width of each address (2**ADDR_WIDTH = 32 registers).
REQ-003 The block SHALL have port clk  input  1  single clock; all writes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port address_A  input  ADDR_WIDTH  read port A register index.
REQ-006 The block SHALL have port address_B  input  ADDR_WIDTH  read port B register index.
REQ-007 The block SHALL have port address_W  input  ADDR_WIDTH  write port register index.
REQ-008 The block SHALL have port write_data  input  DATA_WIDTH  value to write.
REQ-009 The block SHALL have port write_enable  input  1  active-high write strobe.
REQ-010 The block SHALL have port reg_A  output  DATA_WIDTH  contents of register address_A.
REQ-011 The block SHALL have port reg_B  output  DATA_WIDTH  contents of register address_B.

Function
REQ-012 Storage SHALL be an array named gpregs of 32 DATA_WIDTH-bit registers, indices 0-31, visible hierarchically to benches.
REQ-013 Reads SHALL be purely combinational: reg_A = gpregs[address_A], reg_B = gpregs[address_B]; zero-cycle latency, no clock involvement.
REQ-014 On rising clk with rst high, write_enable=1 and address_W!=0: gpregs[address_W] <= write_data; 1-cycle write latency.
REQ-015 write_enable=0 SHALL leave all registers unchanged.
REQ-016 Register 0 SHALL be hardwired zero: writes to address 0 ignored; reads of address 0 always return 0.
REQ-017 Both read ports SHALL be independent; address_A==address_B returns identical values.
REQ-018 Read-during-write to same address: before the edge, port returns old value; after the edge, new value; no write-through bypass.
REQ-019 No X SHALL ever appear on reg_A/reg_B after first reset assertion.

Reset
REQ-020 While rst=0, all 32 registers SHALL be held at 0 immediately, independent of clk.
REQ-021 While rst=0, reg_A and reg_B SHALL read 0 for every address.
REQ-022 Writes SHALL be blocked while rst=0, including write_enable=1 at a clock edge during reset.
REQ-023 Reset asserted mid-operation SHALL clear all previously written contents asynchronously.
REQ-024 The first write after rst deasserts SHALL occur on the first rising clk edge with write_enable=1.

Structure
REQ-025 A shared package SHALL hold DATA_WIDTH=32, ADDR_WIDTH=5, NUM_REGS=32 and ZERO_REG=0 constants.
REQ-026 One sub-module, regfile_read_port (combinational 32:1 mux with zero-register forcing), SHALL be instantiated twice, once per port.
REQ-027 Write logic and gpregs storage SHALL reside in register_file itself; no latches, single always block for storage.

Verification
REQ-028 rst=0 for 5 cycles, addresses (1,2),(31,5) -> reg_A=reg_B=0x00000000 every sample.
REQ-029 rst=1, write 0xDEADBEEF to reg 5 with write_enable=1, then address_A=5 -> reg_A=0xDEADBEEF after the edge.
REQ-030 Write 0x12345678 to reg 0 -> reading address 0 on both ports returns 0x00000000.
REQ-031 write_enable=0, address_W=7, write_data=0xFFFFFFFF -> reg 7 keeps prior value 0x00000000.
REQ-032 Write 0xA5A5A5A5 to reg 31 and 0x5A5A5A5A to reg 1, then address_A=31, address_B=1 -> 0xA5A5A5A5 / 0x5A5A5A5A; address_A=address_B=31 -> both 0xA5A5A5A5.
REQ-033 After writes, pull rst low between edges -> reg_A/reg_B drop to 0 before next clk edge; the registers still read 0 after rst is released.

Source files
------------

// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
// Shared constants for the general-purpose register file.
//   DATA_WIDTH : register / data port width
//   ADDR_WIDTH : register index width
//   NUM_REGS   : number of architectural registers
//   ZERO_REG   : index of the hardwired-zero register
// ----------------------------------------------------------------------------
package register_file_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
// Combinational NUM_REGS:1 read mux with zero-register forcing.
//   regs : flattened register array (input)
//   addr : register index to read (input)
//   data : selected register contents, zero for the zero register (output)
// ----------------------------------------------------------------------------
module regfile_read_port #(
   parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
   input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
   input  logic [ADDR_WIDTH-1:0]                      addr,
   output logic [DATA_WIDTH-1:0]                      data
);
   import register_file_pkg::*;

   // Storage for the zero register is never written, but forcing here keeps
   // the read result independent of whatever the storage holds.
   always_comb begin
      data = regs[addr];
      if (addr == ADDR_WIDTH'(ZERO_REG))
         data = '0;
   end
endmodule

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// Two-read / one-write register file; register 0 hardwired to zero.
//   clk          : write clock (rising edge)
//   rst          : asynchronous active-low reset, clears every register
//   address_A/B  : read port indices (combinational reads)
//   address_W    : write index
//   write_data   : value to write
//   write_enable : active-high write strobe
//   reg_A/reg_B  : read port data
// ----------------------------------------------------------------------------
module register_file #(
   parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address_A,
   input  logic [ADDR_WIDTH-1:0] address_B,
   input  logic [ADDR_WIDTH-1:0] address_W,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] reg_A,
   output logic [DATA_WIDTH-1:0] reg_B
);
   import register_file_pkg::*;

   localparam int NREGS = 2**ADDR_WIDTH;

   logic [NREGS-1:0][DATA_WIDTH-1:0] gpregs;

   // Writes to the zero register are dropped so its storage stays at the
   // reset value; no bypass, so same-address reads see the new value only
   // after the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         gpregs <= '0;
      else if (write_enable && (address_W != ADDR_WIDTH'(ZERO_REG)))
         gpregs[address_W] <= write_data;
   end

   regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_a (
      .regs (gpregs),
      .addr (address_A),
      .data (reg_A)
   );

   regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port_b (
      .regs (gpregs),
      .addr (address_B),
      .data (reg_B)
   );
endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file against an array-based model.
// ----------------------------------------------------------------------------
module tb_register_file;
   logic        clk;
   logic        rst;
   logic [4:0]  address_A, address_B, address_W;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] reg_A, reg_B;

   int errors = 0;
   int checks = 0;

   // Behavioural model: 32 words, index 0 always reads zero.
   logic [31:0] model [32];

   register_file dut (
      .clk          (clk),
      .rst          (rst),
      .address_A    (address_A),
      .address_B    (address_B),
      .address_W    (address_W),
      .write_data   (write_data),
      .write_enable (write_enable),
      .reg_A        (reg_A),
      .reg_B        (reg_B)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : model[a];
   endfunction

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic we);
      @(negedge clk);
      address_W    = a;
      write_data   = d;
      write_enable = we;
      @(posedge clk);
      if (we && rst && a != 5'd0) model[a] = d;
      #1;
      write_enable = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      write_enable = 1'b1;  // must be blocked while in reset
      address_W    = 5'd3;
      write_data   = 32'hFFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         address_A = (c % 2 != 0) ? 5'd31 : 5'd1;
         address_B = (c % 2 != 0) ? 5'd5  : 5'd2;
         #1;
         checks++;
         if (reg_A !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdA cycle %0d: got %h want 00000000", c, reg_A);
         end
         checks++;
         if (reg_B !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdB cycle %0d: got %h want 00000000", c, reg_B);
         end
      end
      @(negedge clk);
      rst          = 1'b1;
      write_enable = 1'b0;
      address_A    = 5'd3;
      #1;
      checks++;
      if (reg_A !== 32'h0) begin
         errors++;
         $display("FAIL reset_blocks_write: reg3 got %h want 00000000", reg_A);
      end
   endtask

   task automatic test_basic_write();
      @(negedge clk);
      address_A    = 5'd5;
      address_W    = 5'd5;
      write_data   = 32'hDEAD_BEEF;
      write_enable = 1'b1;
      #1;
      checks++;
      if (reg_A !== 32'h0) begin
         errors++;
         $display("FAIL rdw_before_edge: got %h want 00000000", reg_A);
      end
      @(posedge clk);
      model[5] = 32'hDEAD_BEEF;
      #1;
      write_enable = 1'b0;
      checks++;
      if (reg_A !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_reg5: got %h want deadbeef", reg_A);
      end
   endtask

   task automatic test_zero_reg();
      do_write(5'd0, 32'h1234_5678, 1'b1);
      address_A = 5'd0;
      address_B = 5'd0;
      #1;
      checks++;
      if (reg_A !== 32'h0 || reg_B !== 32'h0) begin
         errors++;
         $display("FAIL zero_reg: got A=%h B=%h want 00000000", reg_A, reg_B);
      end
      checks++;
      if (dut.gpregs[0] !== 32'h0) begin
         errors++;
         $display("FAIL zero_reg_storage: got %h want 00000000", dut.gpregs[0]);
      end
   endtask

   task automatic test_write_disable();
      do_write(5'd7, 32'hFFFF_FFFF, 1'b0);
      address_A = 5'd7;
      #1;
      checks++;
      if (reg_A !== 32'h0) begin
         errors++;
         $display("FAIL write_disable: reg7 got %h want 00000000", reg_A);
      end
   endtask

   task automatic test_dual_port();
      do_write(5'd31, 32'hA5A5_A5A5, 1'b1);
      do_write(5'd1,  32'h5A5A_5A5A, 1'b1);
      address_A = 5'd31;
      address_B = 5'd1;
      #1;
      checks++;
      if (reg_A !== 32'hA5A5_A5A5 || reg_B !== 32'h5A5A_5A5A) begin
         errors++;
         $display("FAIL dual_port: got A=%h B=%h want a5a5a5a5/5a5a5a5a", reg_A, reg_B);
      end
      address_B = 5'd31;
      #1;
      checks++;
      if (reg_A !== 32'hA5A5_A5A5 || reg_B !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL same_addr: got A=%h B=%h want a5a5a5a5", reg_A, reg_B);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         do_write(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
         address_A = 5'($urandom_range(0, 31));
         address_B = (i % 8 == 0) ? address_A : 5'($urandom_range(0, 31));
         #1;
         checks++;
         if (reg_A !== model_rd(address_A)) begin
            errors++;
            $display("FAIL rand_rdA[%0d] addr %0d: got %h want %h", i, address_A, reg_A, model_rd(address_A));
         end
         checks++;
         if (reg_B !== model_rd(address_B)) begin
            errors++;
            $display("FAIL rand_rdB[%0d] addr %0d: got %h want %h", i, address_B, reg_B, model_rd(address_B));
         end
      end
   endtask

   task automatic test_async_reset();
      do_write(5'd9,  32'h0BAD_F00D, 1'b1);
      do_write(5'd20, 32'hCAFE_0001, 1'b1);
      address_A = 5'd9;
      address_B = 5'd20;
      #1;
      checks++;
      if (reg_A !== model_rd(5'd9) || reg_B !== model_rd(5'd20)) begin
         errors++;
         $display("FAIL pre_async: got A=%h B=%h want %h/%h", reg_A, reg_B, model_rd(5'd9), model_rd(5'd20));
      end
      // Drop reset between edges; outputs must clear before the next edge.
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (reg_A !== 32'h0 || reg_B !== 32'h0) begin
         errors++;
         $display("FAIL async_clear: got A=%h B=%h want 00000000", reg_A, reg_B);
      end
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         address_A = 5'(i);
         address_B = 5'(31 - i);
         #1;
         checks++;
         if (reg_A !== 32'h0 || reg_B !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_sweep %0d: got A=%h B=%h want 00000000", i, reg_A, reg_B);
         end
      end
      // First write after release lands on the first enabled edge.
      do_write(5'd4, 32'h1357_9BDF, 1'b1);
      address_A = 5'd4;
      #1;
      checks++;
      if (reg_A !== 32'h1357_9BDF) begin
         errors++;
         $display("FAIL first_write_after_reset: got %h want 13579bdf", reg_A);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      address_A = '0; address_B = '0; address_W = '0;
      write_data = '0; write_enable = 1'b0; rst = 1'b0;
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_write_disable();
      test_dual_port();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
